// File: rtl/cordic_nco_ctrl.sv
// Angle/amplitude sequencer for a pipelined CORDIC rotator used as an NCO.
// Owns the phase accumulator, the config handshake and the output-valid delay line.
module cordic_nco_ctrl #(
   parameter int unsigned XY_SZ   = 16,
   parameter int unsigned LAT     = 16,
   parameter logic [XY_SZ-1:0] AMP_RST = 16'h4DBA
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic             sync_clr,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [31:0]      cfg_freq,
   input  logic [31:0]      cfg_phase,
   input  logic [XY_SZ-1:0] cfg_amp,
   output logic [31:0]      angle,
   output logic [XY_SZ-1:0] Xin,
   output logic [XY_SZ-1:0] Yin,
   output logic             angle_valid,
   output logic             out_valid,
   output logic             busy
);

   localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      freq_q, freq_d;
   logic [31:0]      phase_q, phase_d;
   logic [XY_SZ-1:0] amp_q, amp_d;
   logic [31:0]      angle_q, angle_d;
   logic [XY_SZ-1:0] xin_q, xin_d;
   logic             av_q, av_d;
   logic [LAT-1:0]   dly_q, dly_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rdy_q, rdy_d;
   logic             active;
   logic             xfer;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      freq_d  = freq_q;
      phase_d = phase_q;
      amp_d   = amp_q;
      angle_d = angle_q;
      xin_d   = xin_q;
      av_d    = 1'b0;
      cnt_d   = cnt_q;

      active = run && ((state_q == IDLE) || (state_q == RUN));
      xfer   = cfg_valid && rdy_q;

      case (state_q)
         RUN: begin
            if (!run) begin
               state_d = DRAIN;
               cnt_d   = CW'(LAT - 1);
            end
         end
         DRAIN: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: ;
      endcase

      // Active edge consumes the registers as they were before any transfer on this edge.
      if (active) begin
         angle_d = acc_q + phase_q;
         acc_d   = acc_q + freq_q;
         xin_d   = amp_q;
         av_d    = 1'b1;
         state_d = RUN;
      end

      if (sync_clr) acc_d = '0;

      if (xfer) begin
         freq_d  = cfg_freq;
         phase_d = cfg_phase;
         amp_d   = cfg_amp;
      end

      rdy_d = (state_d != DRAIN);

      dly_d[0] = av_q;
      for (int unsigned i = 1; i < LAT; i++) dly_d[i] = dly_q[i-1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         freq_q  <= '0;
         phase_q <= '0;
         amp_q   <= AMP_RST;
         angle_q <= '0;
         xin_q   <= '0;
         av_q    <= 1'b0;
         dly_q   <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         freq_q  <= freq_d;
         phase_q <= phase_d;
         amp_q   <= amp_d;
         angle_q <= angle_d;
         xin_q   <= xin_d;
         av_q    <= av_d;
         dly_q   <= dly_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
      end
   end

   assign angle       = angle_q;
   assign Xin         = xin_q;
   assign Yin         = '0;
   assign angle_valid = av_q;
   assign out_valid   = dly_q[LAT-1];
   assign busy        = (state_q != IDLE);
   assign cfg_ready   = rdy_q;

endmodule

// File: doc/cordic_nco_ctrl.md
CORDIC_NCO_CTRL -- requirements
Module: cordic_nco_ctrl

Interface
REQ-001 Parameter XY_SZ, default 16: width of the Xin/Yin drive and cfg_amp.
REQ-002 Parameter LAT, default 16: CORDIC rotator latency in clocks, from angle/Xin/Yin to Xout/Yout.
REQ-003 Parameter AMP_RST, default 16'h4DBA: reset amplitude, approx. 0.6073 x 2^15, which cancels the rotator gain of approx. 1.647.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 run  in  1  level request to generate angles.
REQ-007 sync_clr  in  1  one-cycle pulse that zeroes the phase accumulator.
REQ-008 cfg_valid  in  1  configuration offer.
REQ-009 cfg_ready  out  1  configuration accept.
REQ-010 cfg_freq  in  32  phase increment per sample; 2^32 = one full turn.
REQ-011 cfg_phase  in  32  phase offset added to the accumulator.
REQ-012 cfg_amp  in  XY_SZ  signed amplitude driven on Xin.
REQ-013 angle  out  32  registered rotation angle to the rotator; modulo 2^32; 0 = 0 deg.
REQ-014 Xin  out  XY_SZ  signed registered rotator X input.
REQ-015 Yin  out  XY_SZ  signed registered rotator Y input; always 0.
REQ-016 angle_valid  out  1  the current angle/Xin/Yin is a real sample.
REQ-017 out_valid  out  1  the rotator output this cycle corresponds to a real sample.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The block SHALL implement three states:
- IDLE: reset state.
- RUN.
- DRAIN.
REQ-020 An edge is "active" when run=1 and state is IDLE or RUN.
REQ-021 On an active edge, the block SHALL:
- set angle <= acc + phase_reg (mod 2^32);
- set acc <= acc + freq_reg (mod 2^32; wrap silently, no flag);
- set Xin <= amp_reg;
- set angle_valid <= 1;
- set state <= RUN.
REQ-022 In RUN with run=0, the block SHALL:
- go to DRAIN;
- set angle_valid <= 0;
- hold angle, Xin and acc;
- load drain counter with LAT-1.
REQ-023 In DRAIN, the block SHALL decrement the counter each edge, go to IDLE on the edge where the counter is 0, and ignore run.
REQ-024 In IDLE with run=0, the block SHALL hold angle, Xin, acc and angle_valid=0.
REQ-025 out_valid SHALL equal angle_valid delayed by exactly LAT clock edges, via a LAT-deep shift register; nothing else drives it.
REQ-026 Handshake:
- cfg_ready=1 in IDLE and RUN, 0 in DRAIN and during reset.
- Transfer occurs on an edge with cfg_valid=1 and cfg_ready=1.
- At the transfer edge, cfg_freq/cfg_phase/cfg_amp are latched into freq_reg/phase_reg/amp_reg.
- The latched values first affect angle/acc/Xin on the following active edge.
- A transfer edge that is also active uses the old values.
REQ-027 sync_clr on any edge SHALL set acc <= 0, overriding the increment on an active edge. angle that edge is still computed from the pre-clear acc. The next active edge outputs angle = phase_reg.
REQ-028 Transfer and sync_clr on the same edge SHALL both take effect; the next active angle = the new cfg_phase.
REQ-029 Yin SHALL be constant 0, and the rotator's Z input SHALL never be driven by anything but angle.

Reset
REQ-030 On reset=1 at an edge, the block SHALL set:
- state=IDLE;
- acc=0, freq_reg=0, phase_reg=0, amp_reg=AMP_RST;
- angle=0, Xin=0, Yin=0;
- angle_valid=0, out_valid=0, the whole delay line=0;
- drain counter=0, busy=0, cfg_ready=0.
REQ-031 Reset SHALL take priority over run, sync_clr and the handshake.
REQ-032 Reset asserted mid-RUN or mid-DRAIN SHALL abort immediately; no out_valid pulse from pre-reset samples may appear afterwards.
REQ-033 cfg_ready SHALL return to 1 on the first edge after reset deasserts.

Verification
REQ-034 Wrap: configure freq=32'h4000_0000, phase=0, then run=1 for 5 cycles -> angle = 0, 4000_0000, 8000_0000, C000_0000, 0000_0000 with angle_valid=1 on each.
REQ-035 Latency: angle_valid first high at cycle k -> out_valid first high at cycle k+16; run dropped after 5 samples -> out_valid high exactly 5 cycles, busy low by cycle k+5+16.
REQ-036 Clear collision: freq=32'h0100_0000, sync_clr pulsed on the 3rd active edge -> angles 0, 0100_0000, 0200_0000, then 0000_0000.
REQ-037 Config in DRAIN: cfg_valid held from the first DRAIN cycle -> cfg_ready=0 for 16 cycles, transfer on the first IDLE edge, new phase seen on the next active angle.
REQ-038 Reset mid-run: reset asserted 3 cycles after angle_valid rose -> all outputs 0, Xin=0, out_valid stays 0 for 20 cycles with run=0.
REQ-039 Amplitude: cfg_amp=16'h2000 accepted while in RUN -> Xin changes from 16'h4DBA to 16'h2000 on the active edge after the transfer; Yin=0 throughout.
